// File: rtl/move_scheduler_pkg.sv
// move_pkg: shared definitions for the movement scheduler.
//   - 3-bit intent codes driven on movement_intent
//   - scheduler FSM state encoding
//   - pending-bit indices and helpers mapping pending bits <-> intents
package move_pkg;

  localparam logic [2:0] INTENT_NONE    = 3'd0;
  localparam logic [2:0] INTENT_LEFT    = 3'd1;
  localparam logic [2:0] INTENT_RIGHT   = 3'd2;
  localparam logic [2:0] INTENT_ROTATE  = 3'd3;
  localparam logic [2:0] INTENT_DOWN    = 3'd4;
  localparam logic [2:0] INTENT_GRAVITY = 3'd5;

  // Pending-bit positions; buttons 0..3 line up with the debouncer array.
  localparam int P_LEFT  = 0;
  localparam int P_RIGHT = 1;
  localparam int P_ROT   = 2;
  localparam int P_DOWN  = 3;
  localparam int P_GRAV  = 4;
  localparam int NUM_REQ = 5;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_BLANK = 2'd1,
    ST_REQ        = 2'd2,
    ST_GAP        = 2'd3
  } sched_state_e;

  // Fixed priority: GRAVITY > DOWN > ROTATE > LEFT > RIGHT.
  function automatic logic [2:0] pick_winner(input logic [NUM_REQ-1:0] pend);
    if      (pend[P_GRAV])  return INTENT_GRAVITY;
    else if (pend[P_DOWN])  return INTENT_DOWN;
    else if (pend[P_ROT])   return INTENT_ROTATE;
    else if (pend[P_LEFT])  return INTENT_LEFT;
    else if (pend[P_RIGHT]) return INTENT_RIGHT;
    else                    return INTENT_NONE;
  endfunction

  function automatic logic [NUM_REQ-1:0] intent_mask(input logic [2:0] intent);
    logic [NUM_REQ-1:0] m;
    m = '0;
    case (intent)
      INTENT_LEFT:    m[P_LEFT]  = 1'b1;
      INTENT_RIGHT:   m[P_RIGHT] = 1'b1;
      INTENT_ROTATE:  m[P_ROT]   = 1'b1;
      INTENT_DOWN:    m[P_DOWN]  = 1'b1;
      INTENT_GRAVITY: m[P_GRAV]  = 1'b1;
      default:        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// move_scheduler_if: movement handshake between the scheduler and block memory.
//   movement_request  : request valid, held until a response
//   movement_intent   : 3-bit move code, stable while request is high
//   movement_commit   : 1-cycle pulse, move applied
//   movement_declined : 1-cycle pulse, move illegal
//   movement_steal    : 1-cycle pulse, memory preempted, retry later
// master = scheduler side, slave = block memory side.
interface move_scheduler_if;
  logic       movement_request;
  logic [2:0] movement_intent;
  logic       movement_commit;
  logic       movement_declined;
  logic       movement_steal;

  modport master (
    output movement_request, movement_intent,
    input  movement_commit, movement_declined, movement_steal
  );
  modport slave (
    input  movement_request, movement_intent,
    output movement_commit, movement_declined, movement_steal
  );
endinterface

// File: rtl/move_scheduler_btn_debounce.sv
// btn_debounce: one raw button -> 2-FF synchroniser -> debounced level + rise pulse.
//   clk_i   : system clock
//   rst_ni  : synchronous active-low reset
//   btn_i   : raw asynchronous button, active-high
//   level_o : debounced level
//   rise_o  : one-cycle pulse on a debounced 0->1 transition
// The level only follows the synchronised input after DB_CYCLES consecutive
// samples that disagree with it; any agreeing sample restarts the count.
module btn_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          lvl_q, rise_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      rise_q <= 1'b0;
      if (sync_q[1] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        // Counter tops out here: accept the new level and restart.
        lvl_q  <= sync_q[1];
        rise_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: arbitrates button and gravity moves into the block memory
// movement handshake, one request at a time, launched only during blanking.
//   clk_25_175            : sole clock
//   reset                 : synchronous, active-low
//   buttL/T/R/D           : raw buttons (LEFT, ROTATE, RIGHT, DOWN)
//   gametick              : 1-cycle gravity pulse
//   core_busy             : VGA drawing; requests launch only when low
//   mv (master)           : movement request/intent/commit/declined/steal
//   drop_commit           : 1-cycle pulse on committed DOWN or GRAVITY
//   timeout_err           : sticky, set when a request gets no answer
// Optional: MOVE_SCHED_AUTOREPEAT_EN re-arms held L/R/D every REPEAT_CYCLES.
module move_scheduler
  import move_pkg::*;
#(
  parameter int DB_CYCLES      = 250000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int REPEAT_CYCLES  = 3000000
) (
  input  logic clk_25_175,
  input  logic reset,
  input  logic buttL,
  input  logic buttT,
  input  logic buttR,
  input  logic buttD,
  input  logic gametick,
  input  logic core_busy,
  move_scheduler_if.master mv,
  output logic drop_commit,
  output logic timeout_err
);
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [3:0] btn_raw, db_lvl, db_rise;
  assign btn_raw = {buttD, buttT, buttR, buttL};

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [3:0] (
    .clk_i   (clk_25_175),
    .rst_ni  (reset),
    .btn_i   (btn_raw),
    .level_o (db_lvl),
    .rise_o  (db_rise)
  );

  // Re-arm pulses for held buttons (bit order matches the pending vector).
  logic [NUM_REQ-1:0] rpt_set;

`ifdef MOVE_SCHED_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [2:0][RW-1:0] rcnt_q;
  logic [2:0]         rpt_q, r_lvl, r_rise;
  assign r_lvl  = {db_lvl[P_DOWN],  db_lvl[P_RIGHT],  db_lvl[P_LEFT]};
  assign r_rise = {db_rise[P_DOWN], db_rise[P_RIGHT], db_rise[P_LEFT]};

  // Counter starts at 1 on the rise cycle so re-arms land exactly
  // REPEAT_CYCLES apart from the initial edge.
  always_ff @(posedge clk_25_175) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset || !r_lvl[i]) begin
        rcnt_q[i] <= '0;
        rpt_q[i]  <= 1'b0;
      end else if (r_rise[i]) begin
        rcnt_q[i] <= RW'(1);
        rpt_q[i]  <= 1'b0;
      end else if (rcnt_q[i] == RW'(REPEAT_CYCLES - 1)) begin
        rcnt_q[i] <= '0;
        rpt_q[i]  <= 1'b1;
      end else begin
        rcnt_q[i] <= rcnt_q[i] + 1'b1;
        rpt_q[i]  <= 1'b0;
      end
    end
  end
  assign rpt_set = {1'b0, rpt_q[2], 1'b0, rpt_q[1], rpt_q[0]};
`else
  localparam int unused_repeat = REPEAT_CYCLES;
  logic unused_lvl;
  assign unused_lvl = ^db_lvl;
  assign rpt_set    = '0;
`endif

  sched_state_e       state_q;
  logic [NUM_REQ-1:0] pend_q, pend_set, pend_clr;
  logic [2:0]         cur_q, intent_q;
  logic [WW-1:0]      wait_q;
  logic               req_q, drop_q, tmo_q;
  logic               lr_cancel, resp_clear;

  assign pend_set  = {gametick, db_rise} | rpt_set;
  assign lr_cancel = (state_q == ST_IDLE) && pend_q[P_LEFT] && pend_q[P_RIGHT];
  // Steal outranks commit/declined and keeps the pending bit.
  assign resp_clear = (state_q == ST_REQ) && !mv.movement_steal &&
                      (mv.movement_commit || mv.movement_declined);

  always_comb begin
    pend_clr = '0;
    if (lr_cancel)  pend_clr = intent_mask(INTENT_LEFT) | intent_mask(INTENT_RIGHT);
    if (resp_clear) pend_clr = intent_mask(cur_q);
  end

  always_ff @(posedge clk_25_175) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      cur_q    <= INTENT_NONE;
      intent_q <= INTENT_NONE;
      wait_q   <= '0;
      req_q    <= 1'b0;
      drop_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      // Clear wins over a same-cycle edge: that edge merges into the
      // request just answered.
      pend_q <= (pend_q | pend_set) & ~pend_clr;
      drop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!lr_cancel && |pend_q) begin
            cur_q   <= pick_winner(pend_q);
            state_q <= ST_WAIT_BLANK;
          end
        end
        ST_WAIT_BLANK: begin
          if (!core_busy) begin
            state_q  <= ST_REQ;
            req_q    <= 1'b1;
            intent_q <= cur_q;
            wait_q   <= '0;
          end
        end
        ST_REQ: begin
          if (mv.movement_steal || mv.movement_commit || mv.movement_declined ||
              wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
            state_q  <= ST_GAP;
            req_q    <= 1'b0;
            intent_q <= INTENT_NONE;
            if (!mv.movement_steal && mv.movement_commit)
              drop_q <= (cur_q == INTENT_DOWN) || (cur_q == INTENT_GRAVITY);
            if (!mv.movement_steal && !mv.movement_commit && !mv.movement_declined)
              tmo_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;  // ST_GAP: one request-free cycle
      endcase
    end
  end

  assign mv.movement_request = req_q;
  assign mv.movement_intent  = intent_q;
  assign drop_commit         = drop_q;
  assign timeout_err         = tmo_q;
endmodule
